sti_so_rx: RTL and testbench
============================

STI_SO_RX -- requirements
Module: sti_so_rx

Interface
REQ-001 SHALL have port: clk  input  1  single clock, all logic on rising edge.
REQ-002 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-003 SHALL have port: so_data  input  1  serial bit from STI stage, MSB first.
REQ-004 SHALL have port: so_valid  input  1  high for every valid so_data bit; low between frames.
REQ-005 SHALL have port: rx_data  output  32  received frame, right-aligned, zero-extended.
REQ-006 SHALL have port: rx_len  output  2  length code: 0=8b, 1=16b, 2=24b, 3=32b.
REQ-007 SHALL have port: rx_valid  output  1  FIFO head holds a frame.
REQ-008 SHALL have port: rx_ready  input  1  consumer accepts head when rx_valid and rx_ready are both high.
REQ-009 SHALL have port: rx_err  output  1  one-cycle pulse on a malformed frame.
REQ-010 SHALL have port: rx_ovf  output  1  sticky flag: frame dropped because the FIFO was full.
REQ-011 SHALL have port: frame_cnt  output  8  count of accepted frames, wraps 255->0.
REQ-012 SHALL have parameter: FIFO_DEPTH, default 4, number of output FIFO entries (power of 2).

Function
REQ-013 FSM SHALL have states IDLE and RECV; reset state IDLE.
REQ-014 IDLE->RECV on so_valid=1; the sampled bit SHALL be shifted in during the same cycle.
REQ-015 RECV: each cycle with so_valid=1 SHALL do shreg<={shreg[30:0],so_data} and bit_cnt+1; bit_cnt is 6 bits and saturates at 33.
REQ-016 RECV->IDLE on the first cycle with so_valid=0 (frame end); shreg and bit_cnt SHALL clear on that edge.
REQ-017 At frame end, bit_cnt in {8,16,24,32} SHALL push {shreg, bit_cnt/8-1} into the FIFO.
REQ-018 At frame end, any other bit_cnt (including >32) SHALL pulse rx_err for one cycle in the next cycle and push nothing.
REQ-019 Latency: frame end sampled at edge N; with the FIFO empty, rx_valid SHALL be 1 from cycle N+1.
REQ-020 A frame may restart on the cycle immediately after frame end; no gap cycle beyond the single so_valid=0 cycle SHALL be required.
REQ-021 Push with FIFO full and no pop in the same cycle SHALL drop the frame and set rx_ovf=1; rx_ovf clears only on reset.
REQ-022 Simultaneous push and pop while full SHALL accept both; occupancy stays FIFO_DEPTH and rx_ovf is unchanged.
REQ-023 Simultaneous push and pop while empty SHALL leave the new frame at the head with rx_valid=1.
REQ-024 rx_data and rx_len SHALL reflect the FIFO head and stay stable while rx_valid=1 and rx_ready=0.
REQ-025 frame_cnt SHALL increment once per accepted push; dropped and erroneous frames do not count.
REQ-026 FIFO pointers SHALL be log2(FIFO_DEPTH)+1 bits; full = MSBs differ and lower bits equal.

Reset
REQ-027 While reset=1: state=IDLE, shreg=0, bit_cnt=0, FIFO empty, rx_valid=0, rx_data=0, rx_len=0, rx_err=0, rx_ovf=0, frame_cnt=0.
REQ-028 Reset asserted mid-frame SHALL discard the partial frame; no rx_err and no push follow.
REQ-029 so_valid=1 on the first cycle after reset deasserts SHALL start a new frame normally.

Structure
REQ-030 Shared package sti_pkg SHALL hold the length-code constants (LEN_8..LEN_32), the FSM state encoding and the default FIFO_DEPTH.
REQ-031 The output FIFO SHALL be the sub-module sti_rx_fifo (push/pop/full/empty), reusable by other STI blocks.

Verification
REQ-032 8 bits 0xA5 MSB-first, then so_valid=0 -> next cycle rx_valid=1, rx_data=0x000000A5, rx_len=0, frame_cnt=1.
REQ-033 32 bits 0xDEADBEEF back-to-back with a 16-bit frame 0x1234 (1-cycle gap) -> two entries in order, rx_len=3 then 1.
REQ-034 12-bit frame 0xABC -> rx_err pulses once, rx_valid stays 0, frame_cnt unchanged; a 40-bit frame gives the same result.
REQ-035 rx_ready=0, five 8-bit frames 0x01..0x05 -> four held (0x01..0x04), rx_ovf=1, frame_cnt=4; draining yields 0x01..0x04.
REQ-036 FIFO full, rx_ready=1 on the frame-end cycle of 0x55 -> 0x01 popped, 0x55 enters the tail, rx_ovf stays 0.
REQ-037 reset pulsed after 5 bits of a frame, then a clean frame 0x3C -> only 0x3C is delivered, no rx_err.

Source files
------------

// File: rtl/sti_pkg.sv
// Shared definitions for the STI receive path: length codes, FSM encoding,
// FIFO entry layout and frame-length helpers.
package sti_pkg;

  localparam logic [1:0] LEN_8  = 2'd0;
  localparam logic [1:0] LEN_16 = 2'd1;
  localparam logic [1:0] LEN_24 = 2'd2;
  localparam logic [1:0] LEN_32 = 2'd3;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RECV = 1'b1;

  localparam int DEFAULT_FIFO_DEPTH = 4;

  // One past the longest legal frame, so over-long frames stay distinguishable.
  localparam logic [5:0] BIT_CNT_SAT = 6'd33;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  len;
  } rx_entry_t;

  function automatic logic len_ok(input logic [5:0] n);
    return (n == 6'd8) || (n == 6'd16) || (n == 6'd24) || (n == 6'd32);
  endfunction

  function automatic logic [1:0] len_code(input logic [5:0] n);
    logic [1:0] code;
    case (n)
      6'd16:   code = LEN_16;
      6'd24:   code = LEN_24;
      6'd32:   code = LEN_32;
      default: code = LEN_8;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/sti_so_rx_if.sv
// Bundle of the serial input and framed output signals of sti_so_rx.
interface sti_so_rx_if;
  logic        so_data;
  logic        so_valid;
  logic [31:0] rx_data;
  logic [1:0]  rx_len;
  logic        rx_valid;
  logic        rx_ready;
  logic        rx_err;
  logic        rx_ovf;
  logic [7:0]  frame_cnt;

  // master: serial source plus frame consumer; slave: the receiver itself
  modport master (
    output so_data, so_valid, rx_ready,
    input  rx_data, rx_len, rx_valid, rx_err, rx_ovf, frame_cnt
  );
  modport slave (
    input  so_data, so_valid, rx_ready,
    output rx_data, rx_len, rx_valid, rx_err, rx_ovf, frame_cnt
  );
endinterface

// File: rtl/sti_rx_fifo.sv
// Synchronous FIFO with extra-MSB pointers; read data is zero while empty.
module sti_rx_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 34
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] pop_data,
  output logic         full,
  output logic         empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] PTR_ONE = 1;

  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic [W-1:0] mem [DEPTH];
  logic         wr_en;
  logic         rd_en;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  // A pop in the same cycle frees the slot a push into a full FIFO needs.
  assign rd_en = pop && !empty;
  assign wr_en = push && (!full || rd_en);

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PTR_ONE;
      if (rd_en) rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  assign pop_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/sti_so_rx.sv
// Serial-to-frame receiver: assembles MSB-first bits into 8/16/24/32-bit
// frames and queues them for a valid/ready consumer.
module sti_so_rx
  import sti_pkg::*;
#(
  parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        so_data,
  input  logic        so_valid,
  output logic [31:0] rx_data,
  output logic [1:0]  rx_len,
  output logic        rx_valid,
  input  logic        rx_ready,
  output logic        rx_err,
  output logic        rx_ovf,
  output logic [7:0]  frame_cnt,
  output logic [0:0]  fsm_state
);

  logic [0:0]  state;
  logic [31:0] shreg;
  logic [5:0]  bit_cnt;
  logic        frame_end;
  logic        push_req;
  logic        push_acc;
  logic        pop;
  logic        fifo_full;
  logic        fifo_empty;
  rx_entry_t   push_entry;
  rx_entry_t   head_entry;

  assign fsm_state = state;
  assign frame_end = (state == ST_RECV) && !so_valid;
  assign push_req  = frame_end && len_ok(bit_cnt);

  // Handshake: the head transfers on any rising edge where rx_valid and
  // rx_ready are both high; head fields hold steady until that edge.
  assign pop       = !fifo_empty && rx_ready;
  assign push_acc  = push_req && (!fifo_full || pop);

  assign push_entry.data = shreg;
  assign push_entry.len  = len_code(bit_cnt);

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      shreg   <= '0;
      bit_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (so_valid) begin
            state   <= ST_RECV;
            shreg   <= {31'd0, so_data};
            bit_cnt <= 6'd1;
          end
        end
        default: begin
          if (so_valid) begin
            shreg   <= {shreg[30:0], so_data};
            bit_cnt <= (bit_cnt == BIT_CNT_SAT) ? BIT_CNT_SAT : bit_cnt + 6'd1;
          end else begin
            state   <= ST_IDLE;
            shreg   <= '0;
            bit_cnt <= '0;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_err    <= 1'b0;
      rx_ovf    <= 1'b0;
      frame_cnt <= '0;
    end else begin
      rx_err <= frame_end && !len_ok(bit_cnt);
      if (push_req && fifo_full && !pop) rx_ovf <= 1'b1;
      if (push_acc) frame_cnt <= frame_cnt + 8'd1;
    end
  end

  sti_rx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     ($bits(rx_entry_t))
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push_acc),
    .push_data (push_entry),
    .pop       (pop),
    .pop_data  (head_entry),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign rx_valid = !fifo_empty;
  assign rx_data  = head_entry.data;
  assign rx_len   = head_entry.len;

endmodule

// File: tb/tb_sti_so_rx.sv
// Directed bench for sti_so_rx: a frame table plus hand-written sequences
// for back-to-back frames, overflow, full-FIFO pass-through and reset.
module tb_sti_so_rx;
  import sti_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [0:0] fsm_state;
  int         n_checks = 0;
  int         n_fail = 0;
  int         exp_cnt = 0;

  sti_so_rx_if bus();

  always #5 clk = ~clk;

  sti_so_rx #(.FIFO_DEPTH(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .so_data   (bus.so_data),
    .so_valid  (bus.so_valid),
    .rx_data   (bus.rx_data),
    .rx_len    (bus.rx_len),
    .rx_valid  (bus.rx_valid),
    .rx_ready  (bus.rx_ready),
    .rx_err    (bus.rx_err),
    .rx_ovf    (bus.rx_ovf),
    .frame_cnt (bus.frame_cnt),
    .fsm_state (fsm_state)
  );

  typedef struct {
    logic [63:0] data;
    int          nbits;
    logic        exp_valid;
    logic [31:0] exp_data;
    logic [1:0]  exp_len;
    logic        exp_err;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge one cycle after frame end.
  task automatic send_frame(input logic [63:0] data, input int nbits, input logic ready_at_end);
    for (int i = nbits - 1; i >= 0; i--) begin
      bus.so_valid = 1'b1;
      bus.so_data  = data[i];
      bus.rx_ready = 1'b0;
      @(negedge clk);
    end
    bus.so_valid = 1'b0;
    bus.so_data  = 1'b0;
    bus.rx_ready = ready_at_end;
    @(negedge clk);
    bus.rx_ready = 1'b0;
  endtask

  task automatic pop_check(input string name, input logic [31:0] d, input logic [1:0] l);
    chk({name, " rx_valid"}, {31'd0, bus.rx_valid}, 32'd1);
    chk({name, " rx_data"}, bus.rx_data, d);
    chk({name, " rx_len"}, {30'd0, bus.rx_len}, {30'd0, l});
    bus.rx_ready = 1'b1;
    @(negedge clk);
    bus.rx_ready = 1'b0;
  endtask

  task automatic do_reset();
    bus.so_valid = 1'b0;
    bus.so_data  = 1'b0;
    bus.rx_ready = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    chk("rst rx_valid", {31'd0, bus.rx_valid}, 32'd0);
    chk("rst rx_data", bus.rx_data, 32'd0);
    chk("rst rx_len", {30'd0, bus.rx_len}, 32'd0);
    chk("rst rx_err", {31'd0, bus.rx_err}, 32'd0);
    chk("rst rx_ovf", {31'd0, bus.rx_ovf}, 32'd0);
    chk("rst frame_cnt", {24'd0, bus.frame_cnt}, 32'd0);
    chk("rst fsm_state", {31'd0, fsm_state}, {31'd0, ST_IDLE});
    @(negedge clk);
    reset = 1'b0;
    exp_cnt = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic bad_seen;
    vecs[0] = '{64'hA5,          8,  1'b1, 32'h0000_00A5, LEN_8,  1'b0};
    vecs[1] = '{64'hBEEF,        16, 1'b1, 32'h0000_BEEF, LEN_16, 1'b0};
    vecs[2] = '{64'hC0FFEE,      24, 1'b1, 32'h00C0_FFEE, LEN_24, 1'b0};
    vecs[3] = '{64'hDEADBEEF,    32, 1'b1, 32'hDEAD_BEEF, LEN_32, 1'b0};
    vecs[4] = '{64'hABC,         12, 1'b0, 32'h0,         LEN_8,  1'b1};
    vecs[5] = '{64'hAB_CDEF_0123, 40, 1'b0, 32'h0,        LEN_8,  1'b1};
    vecs[6] = '{64'h1,           1,  1'b0, 32'h0,         LEN_8,  1'b1};
    vecs[7] = '{64'h1_2345_6789, 33, 1'b0, 32'h0,         LEN_8,  1'b1};
    vecs[8] = '{64'h00,          8,  1'b1, 32'h0,         LEN_8,  1'b0};
    vecs[9] = '{64'hFFFF_FFFF,   32, 1'b1, 32'hFFFF_FFFF, LEN_32, 1'b0};

    bus.so_valid = 1'b0;
    bus.so_data  = 1'b0;
    bus.rx_ready = 1'b0;
    do_reset();

    // First frame starts on the very first cycle out of reset.
    for (int i = 0; i < 10; i++) begin
      send_frame(vecs[i].data, vecs[i].nbits, 1'b0);
      if (vecs[i].exp_valid) exp_cnt++;
      chk($sformatf("vec%0d rx_valid", i), {31'd0, bus.rx_valid}, {31'd0, vecs[i].exp_valid});
      chk($sformatf("vec%0d rx_data", i), bus.rx_data, vecs[i].exp_data);
      chk($sformatf("vec%0d rx_len", i), {30'd0, bus.rx_len}, {30'd0, vecs[i].exp_len});
      chk($sformatf("vec%0d rx_err", i), {31'd0, bus.rx_err}, {31'd0, vecs[i].exp_err});
      chk($sformatf("vec%0d frame_cnt", i), {24'd0, bus.frame_cnt}, exp_cnt);
      chk($sformatf("vec%0d rx_ovf", i), {31'd0, bus.rx_ovf}, 32'd0);
      bus.rx_ready = vecs[i].exp_valid;
      @(negedge clk);
      bus.rx_ready = 1'b0;
      chk($sformatf("vec%0d drained", i), {31'd0, bus.rx_valid}, 32'd0);
      chk($sformatf("vec%0d err_pulse_end", i), {31'd0, bus.rx_err}, 32'd0);
    end

    // Back-to-back frames separated by a single idle cycle.
    send_frame(64'hDEADBEEF, 32, 1'b0);
    send_frame(64'h1234, 16, 1'b0);
    chk("b2b frame_cnt", {24'd0, bus.frame_cnt}, exp_cnt + 2);
    pop_check("b2b first", 32'hDEAD_BEEF, LEN_32);
    pop_check("b2b second", 32'h0000_1234, LEN_16);
    chk("b2b empty", {31'd0, bus.rx_valid}, 32'd0);

    // Overflow: five frames into a four-entry FIFO with no consumer.
    do_reset();
    for (int i = 1; i <= 5; i++) send_frame(i, 8, 1'b0);
    repeat (3) @(negedge clk);
    chk("ovf rx_ovf", {31'd0, bus.rx_ovf}, 32'd1);
    chk("ovf frame_cnt", {24'd0, bus.frame_cnt}, 32'd4);
    for (int i = 1; i <= 4; i++) pop_check($sformatf("ovf drain%0d", i), i, LEN_8);
    chk("ovf empty", {31'd0, bus.rx_valid}, 32'd0);
    chk("ovf sticky", {31'd0, bus.rx_ovf}, 32'd1);

    // Full FIFO, consumer pops on the same edge the new frame is pushed.
    do_reset();
    for (int i = 1; i <= 4; i++) send_frame(i, 8, 1'b0);
    send_frame(64'h55, 8, 1'b1);
    chk("full_pp rx_ovf", {31'd0, bus.rx_ovf}, 32'd0);
    chk("full_pp frame_cnt", {24'd0, bus.frame_cnt}, 32'd5);
    for (int i = 2; i <= 4; i++) pop_check($sformatf("full_pp drain%0d", i), i, LEN_8);
    pop_check("full_pp tail", 32'h55, LEN_8);
    chk("full_pp empty", {31'd0, bus.rx_valid}, 32'd0);

    // Reset in the middle of a frame discards the partial bits.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      bus.so_valid = 1'b1;
      bus.so_data  = i[0];
      @(negedge clk);
    end
    reset = 1'b1;
    @(negedge clk);
    bus.so_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    bad_seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      bad_seen = bad_seen | bus.rx_err | bus.rx_valid;
    end
    chk("midrst no_err_no_push", {31'd0, bad_seen}, 32'd0);
    send_frame(64'h3C, 8, 1'b0);
    chk("midrst rx_err", {31'd0, bus.rx_err}, 32'd0);
    chk("midrst frame_cnt", {24'd0, bus.frame_cnt}, 32'd1);
    pop_check("midrst frame", 32'h3C, LEN_8);
    chk("midrst empty", {31'd0, bus.rx_valid}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
